// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Drives N_LEDS user LEDs in one of four runtime-selectable patterns. The pattern advances
//   at a rate derived from the system clock.
//     mode 0  binary up/down count
//     mode 1  rotate left/right
//     mode 2  bounce scan
//     mode 3  PWM breathe
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset (release already synchronised upstream)
//     en     1 = run, 0 = freeze counters, pattern and led
//     mode   pattern select (0..3)
//     dir    1 = up / toward MSB, 0 = down / toward LSB (modes 0 and 1 only)
//     led    registered LED drive; a lit LED drives 0 when ACTIVE_LOW
//     tick   registered one-cycle pulse on every pattern or duty step
module led_pattern_gen #(
   parameter int unsigned CLK_HZ          = 27000000,
   parameter int unsigned TICK_HZ         = 2,
   parameter int unsigned BREATHE_STEP_HZ = 512,
   parameter int unsigned N_LEDS          = 6,
   parameter int unsigned PWM_BITS        = 8,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              dir,
   output logic [N_LEDS-1:0] led,
   output logic              tick
);

   localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
   localparam int unsigned BDIV   = CLK_HZ / BREATHE_STEP_HZ;
   localparam int unsigned PRE_W  = $clog2(DIV);
   localparam int unsigned BPRE_W = $clog2(BDIV);

   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DIV - 1);
   localparam logic [BPRE_W-1:0]   BPRE_LAST = BPRE_W'(BDIV - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};

   typedef enum logic [1:0] {
      ModeBinary  = 2'd0,
      ModeRotate  = 2'd1,
      ModeBounce  = 2'd2,
      ModeBreathe = 2'd3
   } mode_e;

   mode_e               mode_q, mode_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [BPRE_W-1:0]   bpre_q, bpre_d;
   logic [N_LEDS-1:0]   pat_q, pat_d;
   logic                bdir_q, bdir_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                ddir_q, ddir_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [N_LEDS-1:0]   led_q, led_d;
   logic                tick_q, tick_d;

   logic                mode_chg;
   logic [N_LEDS-1:0]   lit;
   logic [N_LEDS-1:0]   pat_rol, pat_ror;

   // Rotations written per width so that a single LED simply holds.
   if (N_LEDS > 1) begin : g_rot_multi
      assign pat_rol = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
      assign pat_ror = {pat_q[0], pat_q[N_LEDS-1:1]};
   end else begin : g_rot_single
      assign pat_rol = pat_q;
      assign pat_ror = pat_q;
   end

   assign mode_chg = (mode_e'(mode) != mode_q);

   always_comb begin
      mode_d = mode_q;
      pre_d  = pre_q;
      bpre_d = bpre_q;
      pat_d  = pat_q;
      bdir_d = bdir_q;
      duty_d = duty_q;
      ddir_d = ddir_q;
      pwm_d  = pwm_q;
      led_d  = led_q;
      tick_d = 1'b0;
      lit    = '0;

      if (mode_chg) begin
         // A mode change wins over any step and is taken even while disabled.
         mode_d = mode_e'(mode);
         pre_d  = '0;
         bpre_d = '0;
         pwm_d  = '0;
         unique case (mode_e'(mode))
            ModeBinary: pat_d = '0;
            ModeRotate, ModeBounce: begin
               pat_d  = N_LEDS'(1);
               bdir_d = 1'b1;
            end
            ModeBreathe: begin
               duty_d = '0;
               ddir_d = 1'b1;
            end
         endcase
         // Breathe restarts at duty 0, so nothing is lit on entry.
         lit   = (mode_e'(mode) == ModeBreathe) ? '0 : pat_d;
         led_d = ACTIVE_LOW ? ~lit : lit;
      end else if (en) begin
         if (mode_q == ModeBreathe) begin
            pwm_d = pwm_q + 1'b1;
            // Compare uses the current pwm/duty, giving one cycle of latency on led.
            lit   = {N_LEDS{pwm_q < duty_q}};
            if (bpre_q == BPRE_LAST) begin
               bpre_d = '0;
               tick_d = 1'b1;
               if (ddir_q) begin
                  if (duty_q == DUTY_MAX) begin
                     ddir_d = 1'b0;
                     duty_d = duty_q - 1'b1;
                  end else begin
                     duty_d = duty_q + 1'b1;
                  end
               end else begin
                  if (duty_q == '0) begin
                     ddir_d = 1'b1;
                     duty_d = duty_q + 1'b1;
                  end else begin
                     duty_d = duty_q - 1'b1;
                  end
               end
            end else begin
               bpre_d = bpre_q + 1'b1;
            end
         end else begin
            if (pre_q == PRE_LAST) begin
               pre_d  = '0;
               tick_d = 1'b1;
               unique case (mode_q)
                  ModeBinary: pat_d = dir ? pat_q + 1'b1 : pat_q - 1'b1;
                  ModeRotate: pat_d = dir ? pat_rol : pat_ror;
                  ModeBounce: begin
                     if (N_LEDS == 1) begin
                        pat_d = pat_q;
                     end else if (bdir_q) begin
                        // Turn around on the step that leaves the MSB: no double dwell.
                        if (pat_q[N_LEDS-1]) begin
                           bdir_d = 1'b0;
                           pat_d  = pat_q >> 1;
                        end else begin
                           pat_d  = pat_q << 1;
                        end
                     end else begin
                        if (pat_q[0]) begin
                           bdir_d = 1'b1;
                           pat_d  = pat_q << 1;
                        end else begin
                           pat_d  = pat_q >> 1;
                        end
                     end
                  end
                  ModeBreathe: pat_d = pat_q;
               endcase
            end else begin
               pre_d = pre_q + 1'b1;
            end
            // Use the next pattern so led changes on the same edge tick rises.
            lit = pat_d;
         end
         led_d = ACTIVE_LOW ? ~lit : lit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= ModeBinary;
         pre_q  <= '0;
         bpre_q <= '0;
         pat_q  <= '0;
         bdir_q <= 1'b1;
         duty_q <= '0;
         ddir_q <= 1'b1;
         pwm_q  <= '0;
         led_q  <= {N_LEDS{ACTIVE_LOW}};
         tick_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         pre_q  <= pre_d;
         bpre_q <= bpre_d;
         pat_q  <= pat_d;
         bdir_q <= bdir_d;
         duty_q <= duty_d;
         ddir_q <= ddir_d;
         pwm_q  <= pwm_d;
         led_q  <= led_d;
         tick_q <= tick_d;
      end
   end

   assign led  = led_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a small integer model of the pattern rules.
module tb_led_pattern_gen;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b0;
   logic       dir   = 1'b1;
   logic [1:0] mode  = 2'd0;
   logic [3:0] led;
   logic       tick;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state (plain integers: pattern value, bounce position, duty level).
   int m_mode, m_pre, m_bpre, m_val, m_pos, m_bdir, m_duty, m_ddir, m_pwm, m_led, m_tick;

   led_pattern_gen #(
      .CLK_HZ         (20),
      .TICK_HZ        (2),
      .BREATHE_STEP_HZ(5),
      .N_LEDS         (4),
      .PWM_BITS       (3),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .mode (mode),
      .dir  (dir),
      .led  (led),
      .tick (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pre = 0; m_bpre = 0; m_val = 0; m_pos = 0; m_bdir = 1;
      m_duty = 0; m_ddir = 1; m_pwm = 0; m_led = 15; m_tick = 0;
   endtask

   task automatic model_step();
      bit lit;
      if (!rst_n) begin
         model_reset();
      end else if (int'(mode) != m_mode) begin
         m_mode = int'(mode);
         m_pre = 0; m_bpre = 0; m_pwm = 0; m_tick = 0;
         case (m_mode)
            0: m_val = 0;
            1: begin m_val = 1; m_bdir = 1; end
            2: begin m_pos = 0; m_val = 1; m_bdir = 1; end
            default: begin m_duty = 0; m_ddir = 1; end
         endcase
         m_led = (m_mode == 3) ? 15 : 15 - m_val;
      end else if (en) begin
         m_tick = 0;
         if (m_mode == 3) begin
            lit   = (m_pwm < m_duty);
            m_pwm = (m_pwm + 1) % 8;
            if (m_bpre == 3) begin
               m_bpre = 0;
               m_tick = 1;
               if (m_ddir == 1) begin
                  if (m_duty == 7) begin m_ddir = 0; m_duty = 6; end
                  else m_duty = m_duty + 1;
               end else begin
                  if (m_duty == 0) begin m_ddir = 1; m_duty = 1; end
                  else m_duty = m_duty - 1;
               end
            end else begin
               m_bpre = m_bpre + 1;
            end
            m_led = lit ? 0 : 15;
         end else begin
            if (m_pre == 9) begin
               m_pre  = 0;
               m_tick = 1;
               case (m_mode)
                  0: m_val = (m_val + (dir ? 1 : 15)) % 16;
                  1: m_val = dir ? (m_val * 2) % 16 + m_val / 8 : m_val / 2 + (m_val % 2) * 8;
                  default: begin
                     if (m_bdir == 1) begin
                        if (m_pos == 3) begin m_bdir = 0; m_pos = 2; end
                        else m_pos = m_pos + 1;
                     end else begin
                        if (m_pos == 0) begin m_bdir = 1; m_pos = 1; end
                        else m_pos = m_pos - 1;
                     end
                     m_val = 1 << m_pos;
                  end
               endcase
            end else begin
               m_pre = m_pre + 1;
            end
            m_led = 15 - m_val;
         end
      end else begin
         m_tick = 0;
      end
   endtask

   // One clock: model follows the edge, DUT outputs compared on the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("led", {28'b0, led}, m_led);
      check("tick", {31'b0, tick}, m_tick);
   endtask

   // Run until tick, bounded; report the gap in cycles.
   task automatic tick_after(input string name, input int exp);
      int n;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
      check(name, n, exp);
   endtask

   logic [3:0] bounce_exp [7];
   logic [3:0] rot_exp [4];
   int         lit_cnt;

   initial begin
      bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      rot_exp    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset
      #1 rst_n = 1'b0;
      #1;
      check("reset_led", {28'b0, led}, 32'hF);
      check("reset_tick", {31'b0, tick}, 0);
      model_reset();
      repeat (2) cyc();
      rst_n = 1'b1;
      en    = 1'b1;
      mode  = 2'd0;
      dir   = 1'b1;

      // Binary count up through wrap
      tick_after("bin_first_gap", 10);
      check("bin_first_led", {28'b0, led}, 32'hE);
      for (int i = 2; i <= 16; i++) tick_after("bin_gap", 10);
      check("bin_wrap_led", {28'b0, led}, 32'hF);
      dir = 1'b0;
      tick_after("bin_down_gap", 10);
      check("bin_down_led", {28'b0, led}, 32'h0);
      dir = 1'b1;
      tick_after("bin_up_gap", 10);
      check("bin_up_led", {28'b0, led}, 32'hF);

      // Enable freeze mid-count
      repeat (4) cyc();
      en = 1'b0;
      repeat (25) cyc();
      check("en_hold_led", {28'b0, led}, 32'hF);
      en = 1'b1;
      tick_after("en_resume_gap", 6);
      for (int i = 0; i < 4; i++) tick_after("bin_gap", 10);
      check("pat_0101", {28'b0, led}, 32'hA);

      // Asynchronous reset between edges
      repeat (3) cyc();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_led", {28'b0, led}, 32'hF);
      check("async_rst_tick", {31'b0, tick}, 0);
      model_reset();
      repeat (2) cyc();
      rst_n = 1'b1;
      tick_after("rst_release_gap", 10);
      check("rst_release_led", {28'b0, led}, 32'hE);

      // Mode change on the cycle a step would have fired
      repeat (9) cyc();
      mode = 2'd1;
      cyc();
      check("chg_no_tick", {31'b0, tick}, 0);
      check("chg_rot_init", {28'b0, led}, 32'hE);

      // Rotate
      for (int i = 0; i < 4; i++) begin
         tick_after("rot_gap", 10);
         check("rot_led", {28'b0, led}, {28'b0, ~rot_exp[i]});
      end
      dir = 1'b0;
      tick_after("rot_gap", 10);
      check("rot_right_led", {28'b0, led}, 32'h7);

      // Bounce, dir toggled at random
      mode = 2'd2;
      cyc();
      check("bounce_init", {28'b0, led}, 32'hE);
      for (int i = 0; i < 7; i++) begin
         dir = 1'($urandom_range(0, 1));
         tick_after("bounce_gap", 10);
         check("bounce_led", {28'b0, led}, {28'b0, ~bounce_exp[i]});
      end

      // Breathe: duty 0 for the first four pwm slots, then 1, then 2 ...
      mode = 2'd3;
      cyc();
      check("breathe_init", {28'b0, led}, 32'hF);
      lit_cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (led == 4'h0) lit_cnt++;
         if (k == 4) check("breathe_tick4", {31'b0, tick}, 1);
         if (k == 9) check("breathe_e9_lit", {28'b0, led}, 32'h0);
         if (k == 11) check("breathe_e11_off", {28'b0, led}, 32'hF);
      end
      check("breathe_lit_cnt", lit_cnt, 2);
      repeat (80) cyc();

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) dir = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 9) != 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
